// File: rtl/dtm_dmi_ctrl_pkg.sv
// Shared DMI encodings and controller state for the DTM system-clock side.
package dtm_dmi_ctrl_pkg;

  localparam int DMI_ABITS    = 7;
  localparam int DBUS_M_WIDTH = DMI_ABITS + 34;
  localparam int DBUS_S_WIDTH = 34;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_OK     = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } dmi_state_e;

endpackage

// File: rtl/dtm_dmi_ctrl.sv
// DMI access controller: turns JTAG dmi update/capture events into single
// outstanding requests to the debug module and tracks sticky dmistat.
module dtm_dmi_ctrl
  import dtm_dmi_ctrl_pkg::*;
#(
  parameter int ABITS        = DMI_ABITS,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               dmi_update,
  input  logic [ABITS+33:0]  dmi_update_bits,
  input  logic               dmi_capture,
  output logic [ABITS+33:0]  dmi_capture_bits,
  input  logic               dmireset,
  input  logic               dmihardreset,
  output logic [1:0]         dmistat,
  output logic               dtm_req_valid,
  input  logic               dtm_req_ready,
  output logic [ABITS+33:0]  dtm_req_bits,
  input  logic               dm_resp_valid,
  output logic               dm_resp_ready,
  input  logic [33:0]        dm_resp_bits
);

  localparam int         MW      = ABITS + 34;
  localparam logic [7:0] TO_LAST = 8'(RESP_TIMEOUT - 1);

  dmi_state_e  state;
  logic [7:0]  cnt;
  logic [31:0] rdata;
  logic [1:0]  new_err;
  logic [1:0]  upd_op;
  logic        upd_ok;

  assign upd_op = dmi_update_bits[1:0];
  assign upd_ok = dmi_update && !dmireset && (dmistat == DMI_RESP_OK) &&
                  (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE);

  // Error raised this cycle; a DM response takes precedence over a timeout
  // in the same cycle, and both take precedence over a busy access.
  always_comb begin
    new_err = DMI_RESP_OK;
    if (state == ST_WAIT && dm_resp_valid && dm_resp_bits[1])
      new_err = dm_resp_bits[1:0];
    else if (state == ST_WAIT && !dm_resp_valid && cnt == TO_LAST)
      new_err = DMI_RESP_FAILED;
    else if (state != ST_IDLE && (dmi_update || dmi_capture))
      new_err = DMI_RESP_BUSY;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      rdata            <= '0;
      dmistat          <= DMI_RESP_OK;
      dtm_req_valid    <= 1'b0;
      dm_resp_ready    <= 1'b0;
      dtm_req_bits     <= '0;
      dmi_capture_bits <= '0;
    end else if (dmihardreset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dmistat       <= DMI_RESP_OK;
      dtm_req_valid <= 1'b0;
      dm_resp_ready <= 1'b0;
    end else begin
      if (dmireset)
        dmistat <= DMI_RESP_OK;
      else if (dmistat == DMI_RESP_OK)
        dmistat <= new_err;

      if (dmi_capture)
        dmi_capture_bits <= {dtm_req_bits[MW-1:34], rdata,
                             (state != ST_IDLE) ? DMI_RESP_BUSY : dmistat};

      case (state)
        ST_IDLE: begin
          if (upd_ok) begin
            dtm_req_bits  <= dmi_update_bits;
            dtm_req_valid <= 1'b1;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dtm_req_ready) begin
            dtm_req_valid <= 1'b0;
            dm_resp_ready <= 1'b1;
            cnt           <= '0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dm_resp_valid) begin
            rdata         <= dm_resp_bits[33:2];
            dm_resp_ready <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == TO_LAST)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The abandoned response is swallowed without touching rdata.
          if (dm_resp_valid) begin
            dm_resp_ready <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtm_dmi_ctrl.sv
// Bench for dtm_dmi_ctrl: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_dtm_dmi_ctrl;

  localparam int AB = 7;
  localparam int MW = AB + 34;
  localparam int TO = 255;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          dmi_update;
  logic [MW-1:0] dmi_update_bits;
  logic          dmi_capture;
  logic [MW-1:0] dmi_capture_bits;
  logic          dmireset;
  logic          dmihardreset;
  logic [1:0]    dmistat;
  logic          dtm_req_valid;
  logic          dtm_req_ready;
  logic [MW-1:0] dtm_req_bits;
  logic          dm_resp_valid;
  logic          dm_resp_ready;
  logic [33:0]   dm_resp_bits;

  dtm_dmi_ctrl #(.ABITS(AB), .RESP_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .dmi_update(dmi_update), .dmi_update_bits(dmi_update_bits),
    .dmi_capture(dmi_capture), .dmi_capture_bits(dmi_capture_bits),
    .dmireset(dmireset), .dmihardreset(dmihardreset), .dmistat(dmistat),
    .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready),
    .dtm_req_bits(dtm_req_bits),
    .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready),
    .dm_resp_bits(dm_resp_bits)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: one pending request flag, a count of cycles spent
  // waiting (-1 when not waiting) and a flag for a response still owed.
  bit            m_req;
  int            m_wait;
  bit            m_drain;
  logic [MW-1:0] m_reqbits;
  logic [MW-1:0] m_cap;
  logic [31:0]   m_rdata;
  logic [1:0]    m_stat;

  task automatic model_step();
    bit         busy;
    logic [1:0] err;
    logic [1:0] nstat;
    if (sys_rst) begin
      m_req = 0; m_wait = -1; m_drain = 0;
      m_reqbits = '0; m_cap = '0; m_rdata = '0; m_stat = 2'd0;
    end else if (dmihardreset) begin
      m_req = 0; m_wait = -1; m_drain = 0; m_stat = 2'd0;
    end else begin
      busy = m_req || (m_wait >= 0) || m_drain;
      err  = 2'd0;
      if (m_wait >= 0 && dm_resp_valid && dm_resp_bits[1:0] >= 2'd2) err = dm_resp_bits[1:0];
      else if (m_wait >= 0 && !dm_resp_valid && m_wait + 1 == TO)    err = 2'd2;
      else if (busy && (dmi_update || dmi_capture))                  err = 2'd3;
      nstat = dmireset ? 2'd0 : ((m_stat != 2'd0) ? m_stat : err);
      if (dmi_capture)
        m_cap = {m_reqbits[MW-1:34], m_rdata, busy ? 2'd3 : m_stat};
      if (m_req) begin
        if (dtm_req_ready) begin m_req = 0; m_wait = 0; end
      end else if (m_wait >= 0) begin
        if (dm_resp_valid) begin
          m_rdata = dm_resp_bits[33:2];
          m_wait  = -1;
        end else begin
          m_wait++;
          if (m_wait == TO) begin m_wait = -1; m_drain = 1; end
        end
      end else if (m_drain) begin
        if (dm_resp_valid) m_drain = 0;
      end else if (dmi_update && !dmireset && m_stat == 2'd0 &&
                   (dmi_update_bits[1:0] == 2'd1 || dmi_update_bits[1:0] == 2'd2)) begin
        m_reqbits = dmi_update_bits;
        m_req     = 1;
      end
      m_stat = nstat;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    check("req_valid",  64'(dtm_req_valid),    64'(m_req));
    check("resp_ready", 64'(dm_resp_ready),    64'((m_wait >= 0) || m_drain));
    check("req_bits",   64'(dtm_req_bits),     64'(m_reqbits));
    check("dmistat",    64'(dmistat),          64'(m_stat));
    check("capture",    64'(dmi_capture_bits), 64'(m_cap));
    dmi_update = 0; dmi_capture = 0; dmireset = 0; dmihardreset = 0; dm_resp_valid = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    dmi_update      = 1;
    dmi_update_bits = {a, d, op};
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    dm_resp_valid = 1;
    dm_resp_bits  = {d, r};
  endtask

  initial begin
    sys_rst = 1; dmi_update = 0; dmi_update_bits = '0; dmi_capture = 0;
    dmireset = 0; dmihardreset = 0; dtm_req_ready = 0; dm_resp_valid = 0;
    dm_resp_bits = '0;
    m_req = 0; m_wait = -1; m_drain = 0; m_reqbits = '0; m_cap = '0;
    m_rdata = '0; m_stat = 2'd0;
    #1;
    tick(); tick();
    check("rst_valid", 64'(dtm_req_valid), 64'd0);
    check("rst_ready", 64'(dm_resp_ready), 64'd0);
    check("rst_stat",  64'(dmistat), 64'd0);
    check("rst_cap",   64'(dmi_capture_bits), 64'd0);
    sys_rst = 0;
    tick();

    // Write, accepted on the first valid cycle, OK response after 3 cycles.
    dtm_req_ready = 1;
    issue(2'd2, 7'h10, 32'h8000_0001);
    tick();
    check("wr_valid", 64'(dtm_req_valid), 64'd1);
    check("wr_bits",  64'(dtm_req_bits), 64'({7'h10, 32'h8000_0001, 2'd2}));
    tick();
    check("wr_once",  64'(dtm_req_valid), 64'd0);
    tick(); tick();
    respond(32'h0, 2'd0);
    tick();
    check("wr_stat", 64'(dmistat), 64'd0);
    dmi_capture = 1;
    tick();
    check("wr_cap_st", 64'(dmi_capture_bits[1:0]), 64'd0);

    // Read returning DEADBEEF, then capture.
    issue(2'd1, 7'h04, 32'h0);
    tick(); tick(); tick();
    respond(32'hDEAD_BEEF, 2'd0);
    tick();
    dmi_capture = 1;
    tick();
    check("rd_cap", 64'(dmi_capture_bits), 64'({7'h04, 32'hDEAD_BEEF, 2'd0}));

    // Busy update one cycle into WAIT; sticky until dmireset.
    issue(2'd1, 7'h08, 32'h0);
    tick(); tick(); tick();
    issue(2'd2, 7'h09, 32'h5555_5555);
    tick();
    check("busy_stat",  64'(dmistat), 64'd3);
    check("busy_noreq", 64'(dtm_req_valid), 64'd0);
    respond(32'hCAFE_0001, 2'd0);
    tick();
    issue(2'd1, 7'h0A, 32'h0);
    tick();
    check("busy_ign", 64'(dtm_req_valid), 64'd0);
    dmireset = 1;
    tick();
    check("clr_stat", 64'(dmistat), 64'd0);
    issue(2'd1, 7'h0C, 32'h0);
    tick();
    check("after_clr", 64'(dtm_req_valid), 64'd1);
    tick();
    respond(32'h0BAD_F00D, 2'd0);
    tick();

    // DM never answers: timeout after 255 WAIT cycles, late response drained.
    issue(2'd1, 7'h20, 32'h0);
    tick(); tick();
    repeat (254) tick();
    check("to_early", 64'(dmistat), 64'd0);
    tick();
    check("to_stat",  64'(dmistat), 64'd2);
    check("to_drain", 64'(dm_resp_ready), 64'd1);
    tick(); tick();
    respond(32'h1234_5678, 2'd0);
    tick();
    check("drain_done", 64'(dm_resp_ready), 64'd0);
    dmi_capture = 1;
    tick();
    check("to_cap", 64'(dmi_capture_bits), 64'({7'h20, 32'h0BAD_F00D, 2'd2}));
    dmireset = 1;
    tick();

    // Failure response while already busy keeps busy; dmireset beats update.
    issue(2'd1, 7'h11, 32'h0);
    tick(); tick();
    dmi_capture = 1;
    tick();
    respond(32'h0, 2'd2);
    tick();
    check("sticky", 64'(dmistat), 64'd3);
    dmireset = 1;
    issue(2'd2, 7'h12, 32'h1);
    tick();
    check("rst_win_st", 64'(dmistat), 64'd0);
    check("rst_win_rq", 64'(dtm_req_valid), 64'd0);

    // Hard reset abandons a request the DM never takes.
    dtm_req_ready = 0;
    issue(2'd1, 7'h15, 32'h0);
    tick();
    dmi_capture = 1;
    tick();
    check("req_busy", 64'(dmistat), 64'd3);
    dmihardreset = 1;
    tick();
    check("hr_valid", 64'(dtm_req_valid), 64'd0);
    check("hr_stat",  64'(dmistat), 64'd0);

    // System reset in the middle of WAIT.
    dtm_req_ready = 1;
    issue(2'd1, 7'h16, 32'h0);
    tick(); tick(); tick();
    sys_rst = 1;
    tick();
    check("sr_ready", 64'(dm_resp_ready), 64'd0);
    check("sr_bits",  64'(dtm_req_bits), 64'd0);
    sys_rst = 0;
    tick();

    // Randomized traffic; some segments starve responses to reach timeouts.
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 600; c++) begin
        sys_rst         = ($urandom_range(0, 499) == 0);
        dmi_update      = ($urandom_range(0, 5) == 0);
        dmi_update_bits = {7'($urandom), 32'($urandom), 2'($urandom)};
        dmi_capture     = ($urandom_range(0, 7) == 0);
        dmireset        = ($urandom_range(0, 24) == 0);
        dmihardreset    = ($urandom_range(0, 149) == 0);
        dtm_req_ready   = ($urandom_range(0, 2) != 0);
        dm_resp_valid   = (seg % 2 == 1) ? ($urandom_range(0, 399) == 0)
                                         : ($urandom_range(0, 3) == 0);
        dm_resp_bits    = {32'($urandom), 2'($urandom)};
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dtm_dmi_ctrl.md
Name: dtm_dmi_ctrl

Overview:
Sys_clk-domain DMI access controller of the Debug Transport Module. It sits directly upstream of the debug module on its dtm_req/dm_resp bus. It turns synchronized JTAG dmi Update-DR/Capture-DR events into single outstanding DMI transactions and tracks sticky dmistat (RISC-V Debug 0.13 semantics). It also returns captured data and status to the JTAG shift register.

Parameters:
ABITS, 7, DMI address width; DBUS_M_WIDTH = ABITS+34, DBUS_S_WIDTH = 34
RESP_TIMEOUT, 255, WAIT cycles before declaring the transaction failed (8-bit counter, must be ≥1)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
dmi_update  in  1  one-cycle pulse: Update-DR on dmi register (already synchronized)
dmi_update_bits  in  ABITS+34  {addr[ABITS+33:34], data[33:2], op[1:0]}
dmi_capture  in  1  one-cycle pulse: Capture-DR on dmi register
dmi_capture_bits  out  ABITS+34  {last addr, last rdata, status[1:0]}
dmireset  in  1  pulse: clear sticky dmistat
dmihardreset  in  1  pulse: abandon transaction, clear all state
dmistat  out  2  sticky status for dtmcs: 0 ok, 2 failed, 3 busy
dtm_req_valid  out  1  request valid
dtm_req_ready  in  1  DM accepts request
dtm_req_bits  out  DBUS_M_WIDTH  {addr, data, op}
dm_resp_valid  in  1  DM response valid
dm_resp_ready  out  1  controller accepts response
dm_resp_bits  in  DBUS_S_WIDTH  {data[33:2], resp[1:0]}

Behaviour:
- Reset (sys_rst=1 at an edge): state IDLE. dtm_req_valid=0, dm_resp_ready=0, dtm_req_bits=0, dmistat=0, dmi_capture_bits=0, timeout counter=0.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE: on dmi_update with dmistat==0 and op∈{1 read, 2 write}, latch addr/data/op into dtm_req_bits and go to REQ. dtm_req_valid rises the next cycle (latency 1).
  - op 0 (nop) and op 3 (reserved): no request.
  - Any update while dmistat!=0: ignored entirely.
- REQ: dtm_req_valid=1 and dtm_req_bits held stable until dtm_req_valid&&dtm_req_ready. Then go to WAIT and clear the counter. No timeout in REQ; valid is never withdrawn except by hardreset or reset.
- WAIT: dm_resp_ready=1 and the counter increments each cycle.
  - On dm_resp_valid: latch data into the rdata field for both reads and writes; go to IDLE.
  - If resp==2 or 3 and dmistat==0, dmistat takes that value.
  - If the counter reaches RESP_TIMEOUT with no response: dmistat=2 (if 0), go to DRAIN.
- DRAIN: dm_resp_ready=1. Discard exactly one response, then go to IDLE.
- Busy detection: dmi_update or dmi_capture while state!=IDLE sets dmistat=3 if it was 0. A busy update is ignored.
- Capture: on dmi_capture, dmi_capture_bits = {latched addr, latched rdata, (state!=IDLE)?3:dmistat}. It holds until the next capture.
- Sticky rule: the first nonzero error wins; later errors never overwrite it.
- dmireset: dmistat←0; FSM unaffected. Same cycle as dmi_update: dmireset wins and the update is ignored.
- dmihardreset: next cycle state IDLE, dmistat 0, counter 0, dtm_req_valid 0, dm_resp_ready 0. This abandons the in-flight transaction (valid drop permitted only here). It overrides every other same-cycle event.
- Simultaneous response and timeout in the same WAIT cycle: the response wins; no failure is recorded.
- Only one transaction is ever outstanding.

Decomposition:
- dbg_defines gets DMI_OP_NOP/READ/WRITE, DMI_RESP_OK/FAILED/BUSY, DMI_ABITS, DBUS_M_WIDTH/DBUS_S_WIDTH, and FSM state encodings.
- No sub-module is needed; the timeout counter is inline (module ~200 lines).

Test Plan:
- Write addr 0x10, data 0x80000001, op 2; ready on 1st valid cycle; resp {0,0} after 3 cycles -> req_bits seen once; dmistat 0; capture status 0.
- Read addr 0x04, op 1; DM returns data 0xDEADBEEF, resp 0; then capture -> dmi_capture_bits = {0x04, 0xDEADBEEF, 0}.
- Second update 1 cycle into WAIT -> dmistat 3, no second request. Later update ignored until dmireset; after dmireset the next read issues normally.
- DM never responds -> after 255 WAIT cycles dmistat 2 and state DRAIN. A late response is consumed and discarded, then IDLE; capture rdata unchanged.
- Response resp=2 while dmistat already 3 -> dmistat stays 3. dmireset same cycle as update -> dmistat 0 and no request.
- dmihardreset during REQ with ready held low -> dtm_req_valid 0 next cycle and dmistat 0. sys_rst mid-WAIT -> all outputs 0 next cycle.
